// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle sequencer around the board-level ALU.
// Accepts a one-cycle Go request, latches A/B/Fn and runs either a
// single-cycle function or an iterative shift-add multiply. The result is
// held in a register that drives ALUOut until the next writeback.
//
// Ports:
//   Clock   - system clock, rising edge
//   Reset   - synchronous active-high reset (priority over Go)
//   Go      - request strobe, sampled only while idle
//   A, B    - WIDTH-bit operands, latched on an accepted Go
//   Fn      - 3-bit function select, latched on an accepted Go
//   ALUOut  - 2*WIDTH-bit registered result
//   Busy    - high whenever the sequencer is not idle
//   Done    - one-cycle pulse when the result has been written
//   Carry   - registered carry flag, updated with every writeback
//
// WIDTH must be at least 2 (ROTL uses B[1:0] as its rotate amount).

module alu_op_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Go,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         Fn,
  output logic [2*WIDTH-1:0] ALUOut,
  output logic               Busy,
  output logic               Done,
  output logic               Carry
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] FN_ADD    = 3'd0;
  localparam logic [2:0] FN_LOGIC  = 3'd1;
  localparam logic [2:0] FN_ANY    = 3'd2;
  localparam logic [2:0] FN_CONCAT = 3'd3;
  localparam logic [2:0] FN_MUL    = 3'd4;
  localparam logic [2:0] FN_ACCUM  = 3'd5;
  localparam logic [2:0] FN_ROTL   = 3'd6;
  localparam logic [2:0] FN_HOLD   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        fn_q, fn_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     out_q, out_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Datapath helpers shared by the next-state logic
  logic [RW-1:0]     mul_partial;
  logic [RW-1:0]     mul_sum;
  logic [WIDTH:0]    add_sum;
  logic [RW:0]       accum_sum;
  logic [2*RW-1:0]   rot_dbl;

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and flag logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    carry_d = carry_q;

    // Shift-add step: add A<<cnt when the current multiplier bit is set
    mul_partial = b_q[cnt_q] ? (RW'(a_q) << cnt_q) : '0;
    mul_sum     = acc_q + mul_partial;
    add_sum     = (WIDTH+1)'(a_q) + (WIDTH+1)'(b_q);
    accum_sum   = (RW+1)'(out_q) + (RW+1)'(a_q);
    // Rotate by shifting a doubled copy; the upper half is the rotated value
    rot_dbl     = {out_q, out_q} << b_q[1:0];

    case (state_q)
      S_IDLE: begin
        if (Go) begin
          a_d     = A;
          b_d     = B;
          fn_d    = Fn;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (fn_q == FN_MUL) begin
          acc_d = mul_sum;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            out_d   = mul_sum;
            carry_d = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          carry_d = 1'b0;
          case (fn_q)
            FN_ADD: begin
              out_d   = RW'(add_sum);
              carry_d = add_sum[WIDTH];
            end
            FN_LOGIC:  out_d = {a_q | b_q, a_q ^ b_q};
            FN_ANY:    out_d = (|{a_q, b_q}) ? RW'({WIDTH{1'b1}}) : '0;
            FN_CONCAT: out_d = {b_q, a_q};
            FN_ACCUM: begin
              out_d   = accum_sum[RW-1:0];
              carry_d = accum_sum[RW];
            end
            FN_ROTL:   out_d = rot_dbl[2*RW-1:RW];
            FN_HOLD:   out_d = out_q;
            default:   out_d = out_q;
          endcase
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign ALUOut = out_q;
  assign Carry  = carry_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed operations with literal expected
// values, plus a cycle-by-cycle comparison against a behavioural model.

module tb_alu_op_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Go;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Fn;
  logic [7:0] ALUOut;
  logic       Busy;
  logic       Done;
  logic       Carry;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  alu_op_sequencer #(.WIDTH(4)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Go     (Go),
    .A      (A),
    .B      (B),
    .Fn     (Fn),
    .ALUOut (ALUOut),
    .Busy   (Busy),
    .Done   (Done),
    .Carry  (Carry)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 working (m_left cycles to go), 2 done
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_a, m_b, m_fn;
  logic [7:0] m_out = 8'h00;
  logic       m_c   = 1'b0;

  function automatic void model_result(input int fn, input int a, input int b,
                                       input logic [7:0] prev,
                                       output logic [7:0] res, output logic c);
    int s;
    int p;
    int r;
    p = int'(prev);
    c = 1'b0;
    case (fn)
      0: begin s = a + b; res = 8'(s); c = (s >= 16); end
      1: res = 8'(((a | b) * 16) + (a ^ b));
      2: res = ((a != 0) || (b != 0)) ? 8'h0F : 8'h00;
      3: res = 8'(b * 16 + a);
      4: res = 8'(a * b);
      5: begin s = p + a; res = 8'(s % 256); c = (s >= 256); end
      6: begin r = b % 4; res = 8'(((p << r) | (p >> (8 - r))) % 256); end
      default: res = prev;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_phase = 0; m_left = 0; m_out = 8'h00; m_c = 1'b0;
    end else begin
      case (m_phase)
        0: if (Go) begin
             m_a = int'(A); m_b = int'(B); m_fn = int'(Fn);
             m_left = (Fn == 3'd4) ? 4 : 1;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               model_result(m_fn, m_a, m_b, m_out, m_out, m_c);
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model_aluout", 32'(ALUOut), 32'(m_out));
      check("model_carry",  32'(Carry),  32'(m_c));
      check("model_busy",   32'(Busy),   32'(m_phase != 0));
      check("model_done",   32'(Done),   32'(m_phase == 2));
    end
  end

  // Issue one operation; returns the number of cycles from acceptance to Done
  task automatic run_op(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b,
                        input bit scramble, output int lat);
    @(negedge Clock);
    Go = 1'b1; A = a; B = b; Fn = fn;
    @(negedge Clock);
    Go = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (scramble) begin
        A = 4'($urandom); B = 4'($urandom); Fn = 3'($urandom);
      end
      @(negedge Clock);
      if (Done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int ndone;

  initial begin
    Reset = 1'b1; Go = 1'b0; A = '0; B = '0; Fn = '0;
    repeat (2) @(negedge Clock);
    chk_en = 1'b1;
    check("rst_aluout", 32'(ALUOut), 32'h00);
    check("rst_carry",  32'(Carry),  32'h0);
    check("rst_busy",   32'(Busy),   32'h0);
    check("rst_done",   32'(Done),   32'h0);
    Reset = 1'b0;
    @(negedge Clock);

    run_op(3'd0, 4'd9, 4'd8, 1'b0, lat);
    check("add_lat",   32'(lat),    32'd1);
    check("add_out",   32'(ALUOut), 32'h11);
    check("add_carry", 32'(Carry),  32'h1);
    check("add_busy",  32'(Busy),   32'h1);
    @(negedge Clock);
    check("add_done_once", 32'(Done), 32'h0);
    check("add_idle",      32'(Busy), 32'h0);

    run_op(3'd2, 4'd0, 4'd0, 1'b0, lat);
    check("any00_out",   32'(ALUOut), 32'h00);
    check("any00_carry", 32'(Carry),  32'h0);
    run_op(3'd2, 4'd0, 4'd4, 1'b0, lat);
    check("any04_out",   32'(ALUOut), 32'h0F);

    run_op(3'd4, 4'd15, 4'd15, 1'b1, lat);
    check("mul_lat", 32'(lat),    32'd4);
    check("mul_out", 32'(ALUOut), 32'hE1);
    check("mul_carry", 32'(Carry), 32'h0);

    run_op(3'd3, 4'd1, 4'd8, 1'b0, lat);
    check("concat_out", 32'(ALUOut), 32'h81);
    run_op(3'd6, 4'd0, 4'd1, 1'b0, lat);
    check("rotl_out", 32'(ALUOut), 32'h03);
    run_op(3'd5, 4'd15, 4'd0, 1'b0, lat);
    check("accum1_out", 32'(ALUOut), 32'h12);
    run_op(3'd5, 4'd15, 4'd0, 1'b0, lat);
    check("accum2_out", 32'(ALUOut), 32'h21);
    run_op(3'd5, 4'd15, 4'd0, 1'b0, lat);
    check("accum3_out", 32'(ALUOut), 32'h30);
    check("accum3_carry", 32'(Carry), 32'h0);

    run_op(3'd3, 4'd8, 4'd15, 1'b0, lat);
    check("concat_f8", 32'(ALUOut), 32'hF8);
    run_op(3'd5, 4'd8, 4'd0, 1'b0, lat);
    check("accum_wrap_out",   32'(ALUOut), 32'h00);
    check("accum_wrap_carry", 32'(Carry),  32'h1);
    run_op(3'd7, 4'd3, 4'd3, 1'b0, lat);
    check("hold_lat",   32'(lat),    32'd1);
    check("hold_out",   32'(ALUOut), 32'h00);
    check("hold_carry", 32'(Carry),  32'h0);

    run_op(3'd1, 4'd5, 4'd3, 1'b0, lat);
    check("logic_out", 32'(ALUOut), 32'h76);

    // Go held high: only every third edge is an accepted request
    @(negedge Clock);
    Go = 1'b1; Fn = 3'd0; A = 4'd1; B = 4'd2;
    ndone = 0;
    repeat (9) begin
      @(negedge Clock);
      if (Done === 1'b1) ndone++;
    end
    Go = 1'b0;
    check("gohold_dones", 32'(ndone),  32'd3);
    check("gohold_out",   32'(ALUOut), 32'h03);
    @(negedge Clock);

    // Reset while the multiply counter sits at 2
    run_op(3'd3, 4'd6, 4'd9, 1'b0, lat);
    check("pre_rst_out", 32'(ALUOut), 32'h96);
    @(negedge Clock);
    Go = 1'b1; A = 4'd15; B = 4'd15; Fn = 3'd4;
    @(negedge Clock);
    Go = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_out",  32'(ALUOut), 32'h00);
    check("midrst_busy", 32'(Busy),   32'h0);
    check("midrst_done", 32'(Done),   32'h0);
    ndone = 0;
    repeat (5) begin
      @(negedge Clock);
      if (Done === 1'b1) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);

    run_op(3'd0, 4'd3, 4'd4, 1'b0, lat);
    check("post_rst_add", 32'(ALUOut), 32'h07);
    check("post_rst_carry", 32'(Carry), 32'h0);
    repeat (3) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle sequencer wrapping the board-level 4-bit ALU.
- Accepts a one-cycle Go request carrying two operands and a function code, then latches them.
- Runs the selected operation, which is single-cycle or iterative shift-add multiply, and holds the 8-bit result in a register that drives ALUOut.
- Provides the Busy/Done handshake so the KEY/SW front end or a future command scheduler can issue operations back to back.

Parameters:
- WIDTH, 4, operand width. Result width is 2*WIDTH. Multiply iteration count is WIDTH.

Ports:
- Clock, input, 1, system clock; all state updates on its rising edge.
- Reset, input, 1, synchronous active-high reset.
- Go, input, 1, request strobe; sampled only in IDLE.
- A, input, WIDTH, operand A; latched on accepted Go.
- B, input, WIDTH, operand B; latched on accepted Go.
- Fn, input, 3, function select; latched on accepted Go.
- ALUOut, output, 2*WIDTH, registered result; holds its value until the next writeback.
- Busy, output, 1, high whenever the state is not IDLE.
- Done, output, 1, one-cycle pulse in the DONE state.
- Carry, output, 1, registered carry flag; updated with every writeback.

Behaviour:
- Reset: state IDLE; ALUOut=0, Carry=0, Busy=0, Done=0. Operand latches, iteration counter and multiply accumulator all clear to 0.
- Reset asserted mid-operation (any state) aborts the operation; the same reset values apply on the next edge. Reset has priority over Go.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE with Go=1 at edge k: latch A, B, Fn; move to EXEC. Busy=1 from edge k.
- EXEC, single-cycle Fn: at edge k+1 write ALUOut/Carry and move to DONE. Done=1 for exactly one cycle after k+1; back to IDLE at edge k+2.
- EXEC, MUL: counter runs 0..WIDTH-1. Each edge: if B_latched[counter]=1, add A_latched<<counter into the accumulator. After the edge at which counter=WIDTH-1, write ALUOut and move to DONE. Default total: Go edge k, result edge k+4, Done after k+4, IDLE at k+5.
- Go while Busy=1, including in DONE, is ignored. No queuing, no error flag.
- A/B/Fn changing after Go has no effect on the running operation.
- Function codes (widths shown at default WIDTH=4; all arithmetic unsigned):
  - 0 ADD: ALUOut = {3'b0, A+B}. Carry = bit 4 of the sum (A+B >= 16).
  - 1 LOGIC: ALUOut = {A|B, A^B}. Carry = 0.
  - 2 ANY: ALUOut = 8'h0F if any bit of A or B is 1, else 8'h00. Carry = 0.
  - 3 CONCAT: ALUOut = {B, A}. Carry = 0.
  - 4 MUL: ALUOut = A*B (full 8 bits, never overflows). Carry = 0.
  - 5 ACCUM: ALUOut = ALUOut + {4'b0, A}, wrapping modulo 256. Carry = carry out of bit 7. Uses the previous registered ALUOut.
  - 6 ROTL: ALUOut = previous ALUOut rotated left by B[1:0]. Carry = 0.
  - 7 HOLD: ALUOut unchanged. Carry cleared to 0. Still passes through EXEC/DONE with a Done pulse.
- ALUOut and Carry change only at writeback edges or on reset; no glitching.
- In DONE, Busy=1 and Done=1 together.

Test Plan:
- Reset, then ADD A=9, B=8 -> at edge k+1 ALUOut=8'h11, Carry=1; Done high for exactly one cycle; Busy high during cycles k..k+2.
- ANY with A=0, B=0 -> ALUOut=8'h00. ANY with A=0, B=4 -> ALUOut=8'h0F. Carry=0 in both.
- MUL A=15, B=15 -> ALUOut=8'hE1 at edge k+4, Done after k+4. Toggling A/B mid-operation does not change the result.
- CONCAT A=1, B=8 -> ALUOut=8'h81. Then ROTL with B=1 -> ALUOut=8'h03. Then ACCUM A=15 three times -> 8'h12, 8'h21, 8'h30. Then 8'hF8 + 8 -> ALUOut=8'h00, Carry=1.
- Go held high continuously -> a new operation is accepted only in IDLE, i.e. every 3rd cycle for single-cycle ops; pulses during EXEC/DONE are ignored.
- Reset asserted during MUL at counter=2 -> next edge ALUOut=0, Busy=0, no Done pulse. A following ADD 3+4 gives 8'h07.
